temp_sensor_spi_reader: RTL and testbench

SPI master that reads a serial temperature sensor (CPOL=1, MSB first, read-only) on command or periodically, and holds the last result.
Its data_ready level output drives the 1-bit GO parallel input port, whose edge capture raises the CPU interrupt.
Software reads sample through a separate data PIO and pulses ack to release data_ready.

---
 rtl/temp_sensor_spi_reader.sv | 205 ++++++++++++++++++++
 tb/tb_temp_sensor_spi_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/temp_sensor_spi_reader.sv
// SPI master for a read-only serial temperature sensor (CPOL=1, MSB first).
// A conversion runs on a start pulse. When TSR_PERIODIC_EN is defined, an
// internal period counter can also request conversions.
// The last result is held in sample. data_ready flags it until ack.
// Optional feature macro: TSR_PERIODIC_EN (periodic conversion requests).
module temp_sensor_spi_reader #(
    parameter int unsigned CLK_DIV       = 25,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned CS_SETUP      = 2,
    parameter int unsigned SAMPLE_PERIOD = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 enable,
    input  logic                 ack,
    input  logic                 spi_miso,
    output logic                 spi_sclk,
    output logic                 spi_cs_n,
    output logic [DATA_BITS-1:0] sample,
    output logic                 data_ready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned CNT_MAX = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CS_LAST  = CNT_W'(CS_SETUP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StHold
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic                   sclk_q, sclk_d;
    logic                   cs_n_q, cs_n_d;
    logic                   busy_q, busy_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   sample_q, sample_d;
    logic                   ready_q, ready_d;
    logic                   overrun_q, overrun_d;
    logic                   miso_s1_q, miso_s2_q;
    logic                   tick;
    logic                   req;

`ifdef TSR_PERIODIC_EN
    localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD);

    logic [PER_W-1:0] period_q;

    assign tick = enable && (period_q == PER_W'(SAMPLE_PERIOD - 1));

    // Free-running period counter; held at zero while periodic mode is off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= '0;
        end else if (!enable || tick) begin
            period_q <= '0;
        end else begin
            period_q <= period_q + 1'b1;
        end
    end
`else
    logic [32:0] unused_periodic;

    assign unused_periodic = {enable, SAMPLE_PERIOD};
    assign tick            = 1'b0;
`endif

    // A simultaneous tick and start collapse into one request.
    assign req = start | tick;

    // Two-flop synchroniser for the asynchronous sensor data line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    // Next-state logic: conversion sequencing plus result/flag handling.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        shift_d   = shift_q;
        sample_d  = sample_q;
        ready_d   = ready_q;
        overrun_d = overrun_q;

        if (ack) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StSetup;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b1;
                end
            end
            StSetup: begin
                if (cnt_q == CS_LAST) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising SCLK edge: capture the synchronised data bit.
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[DATA_BITS-2:0], miso_s2_q};
                    end else if (bit_q == BIT_LAST) begin
                        // Final high phase done; SCLK stays high into HOLD.
                        state_d = StHold;
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == CS_LAST) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    bit_d    = '0;
                    cs_n_d   = 1'b1;
                    busy_d   = 1'b0;
                    sample_d = shift_q;
                    // Completion beats a same-cycle ack; ack still suppresses overrun.
                    ready_d   = 1'b1;
                    overrun_d = ack ? 1'b0 : (overrun_q | ready_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset also aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            sample_q  <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            sample_q  <= sample_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    assign spi_sclk   = sclk_q;
    assign spi_cs_n   = cs_n_q;
    assign sample     = sample_q;
    assign data_ready = ready_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_temp_sensor_spi_reader.sv
// Directed bench for temp_sensor_spi_reader: a vector table of conversions,
// plus hand-written reset-abort and periodic-mode sequences.
module tb_temp_sensor_spi_reader;

    localparam int unsigned CLK_DIV       = 2;
    localparam int unsigned DATA_BITS     = 16;
    localparam int unsigned CS_SETUP      = 2;
    localparam int unsigned SAMPLE_PERIOD = 200;
    localparam int          DONE_LAT      = 2 * CS_SETUP + 2 * CLK_DIV * DATA_BITS;  // 68
`ifdef TSR_PERIODIC_EN
    localparam int          EXP_PERIODIC  = 5;
`else
    localparam int          EXP_PERIODIC  = 0;
`endif

    logic                 clk;
    logic                 reset_n;
    logic                 start;
    logic                 enable;
    logic                 ack;
    logic                 spi_miso;
    logic                 spi_sclk;
    logic                 spi_cs_n;
    logic [DATA_BITS-1:0] sample;
    logic                 data_ready;
    logic                 busy;
    logic                 overrun;

    int n_vec  = 0;
    int n_fail = 0;

    temp_sensor_spi_reader #(
        .CLK_DIV      (CLK_DIV),
        .DATA_BITS    (DATA_BITS),
        .CS_SETUP     (CS_SETUP),
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .enable    (enable),
        .ack       (ack),
        .spi_miso  (spi_miso),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .sample    (sample),
        .data_ready(data_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sensor model: MSB presented at CS fall, next bit after each SCLK rise.
    logic [15:0] cur_word = 16'h0000;
    int          bit_idx  = 0;
    int          rise_cnt = 0;
    int          cs_falls = 0;
    time         fall_t [8];

    always @(negedge spi_cs_n) begin
        bit_idx  = 0;
        spi_miso = cur_word[15];
        if (cs_falls < 8) fall_t[cs_falls] = $time;
        cs_falls++;
    end

    always @(posedge spi_sclk) begin
        rise_cnt++;
        if (!spi_cs_n) begin
            bit_idx++;
            spi_miso = (bit_idx < 16) ? cur_word[15 - bit_idx] : 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic        ack_before;
        logic        mid_start;
        logic        ack_on_done;
        logic [15:0] exp_sample;
        logic        exp_ready;
        logic        exp_overrun;
    } vec_t;

    // One full conversion with optional ack/start injections, then checks.
    task automatic run_vec(input string tag, input vec_t v);
        int n;
        if (v.ack_before) begin
            @(negedge clk) ack = 1'b1;
            @(negedge clk) ack = 1'b0;
            check({tag, "_ack_ready"}, 32'(data_ready), 32'd0);
            check({tag, "_ack_overrun"}, 32'(overrun), 32'd0);
        end
        cur_word = v.word;
        rise_cnt = 0;
        cs_falls = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_cs_latency"}, 32'(spi_cs_n), 32'd0);
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 200) begin
            if (v.ack_on_done && n == DONE_LAT - 1) ack = 1'b1;
            if (v.mid_start && n == 20) start = 1'b1;
            @(negedge clk);
            ack   = 1'b0;
            start = 1'b0;
            n++;
        end
        check({tag, "_done_latency"}, 32'(n), 32'(DONE_LAT));
        check({tag, "_sclk_rises"}, 32'(rise_cnt), 32'd16);
        check({tag, "_sample"}, 32'(sample), 32'(v.exp_sample));
        check({tag, "_ready"}, 32'(data_ready), 32'(v.exp_ready));
        check({tag, "_overrun"}, 32'(overrun), 32'(v.exp_overrun));
        check({tag, "_cs_idle"}, 32'(spi_cs_n), 32'd1);
        repeat (6) @(negedge clk);
        check({tag, "_no_requeue"}, 32'(cs_falls), 32'd1);
    endtask

    vec_t vecs [6];

    initial begin
        int n;
        vec_t v;

        vecs[0] = '{16'h1A5C, 1'b0, 1'b0, 1'b0, 16'h1A5C, 1'b1, 1'b0};
        vecs[1] = '{16'h3C3C, 1'b1, 1'b1, 1'b0, 16'h3C3C, 1'b1, 1'b0};  // start while busy
        vecs[2] = '{16'h0F00, 1'b0, 1'b0, 1'b0, 16'h0F00, 1'b1, 1'b1};  // overrun
        vecs[3] = '{16'h8001, 1'b0, 1'b0, 1'b1, 16'h8001, 1'b1, 1'b0};  // ack on completion
        vecs[4] = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h7FFE, 1'b0, 1'b0, 1'b0, 16'h7FFE, 1'b1, 1'b1};

        start    = 1'b0;
        enable   = 1'b0;
        ack      = 1'b0;
        spi_miso = 1'b0;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        #20;
        check("rst_sclk", 32'(spi_sclk), 32'd1);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_ready", 32'(data_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Reset in the middle of SHIFT, after the 5th SCLK rise.
        cur_word = 16'h1234;
        rise_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (rise_cnt < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_rises", 32'(rise_cnt), 32'd5);
        reset_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(spi_cs_n), 32'd1);
        check("abort_sclk", 32'(spi_sclk), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sample", 32'(sample), 32'd0);
        check("abort_ready", 32'(data_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        v = '{16'hC3A7, 1'b0, 1'b0, 1'b0, 16'hC3A7, 1'b1, 1'b0};
        run_vec("post_abort", v);

        // Periodic mode: enable held for exactly 1000 clock edges.
        @(negedge clk) ack = 1'b1;
        @(negedge clk) ack = 1'b0;
        cur_word = 16'h0042;
        cs_falls = 0;
        @(negedge clk) enable = 1'b1;
        repeat (1000) @(posedge clk);
        #1 enable = 1'b0;
        repeat (150) @(negedge clk);
        check("periodic_count", 32'(cs_falls), 32'(EXP_PERIODIC));
        for (int i = 1; i < cs_falls && i < 8; i++) begin
            check($sformatf("periodic_gap%0d", i), 32'(fall_t[i] - fall_t[i-1]),
                  32'(SAMPLE_PERIOD * 10));
        end
        check("periodic_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
